// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c_master between NUM_REQ requesters, with a watchdog.
// Define I2C_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module i2c_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int TW             = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [7:0]             rsp_rdata,
  output logic                   rsp_err,
  output logic                   m_start,
  output logic                   m_read_write,
  output logic [6:0]             m_slave_addr,
  output logic [7:0]             m_data_in,
  input  logic [7:0]             m_data_out,
  input  logic                   m_busy,
  input  logic                   m_done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t               r_state;
  logic [IW-1:0]        r_win;
  logic [TW-1:0]        r_cnt;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [7:0]           r_rsp_rdata;
  logic                 r_rsp_err;
  logic                 r_m_start;
  logic                 r_m_rw;
  logic [6:0]           r_m_addr;
  logic [7:0]           r_m_wdata;
  logic                 r_busy_s1, r_busy_s;
  logic                 r_done_s1, r_done_s, r_done_s_d;
  logic                 w_done_rise;
  logic [IW-1:0]        w_win;
  logic                 w_any;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

`ifdef I2C_ARB_FIXED_PRIO_EN
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        w_any = 1'b1;
        w_win = IW'(k);
      end
    end
  end
`else
  logic [IW-1:0] r_ptr;

  // Scan downward so the set bit nearest after the pointer is assigned last and wins.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_any = 1'b1;
        w_win = IW'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end
`endif

  // busy/done come from the master's divided SCL domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_s1  <= 1'b0;
      r_busy_s   <= 1'b0;
      r_done_s1  <= 1'b0;
      r_done_s   <= 1'b0;
      r_done_s_d <= 1'b0;
    end else begin
      r_busy_s1  <= m_busy;
      r_busy_s   <= r_busy_s1;
      r_done_s1  <= m_done;
      r_done_s   <= r_done_s1;
      r_done_s_d <= r_done_s;
    end
  end

  assign w_done_rise = r_done_s & ~r_done_s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_win       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_m_start   <= 1'b0;
      r_m_rw      <= 1'b0;
      r_m_addr    <= '0;
      r_m_wdata   <= '0;
`ifndef I2C_ARB_FIXED_PRIO_EN
      r_ptr       <= IW'(NUM_REQ - 1);
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win     <= w_win;
            r_gnt     <= onehot(w_win);
            r_m_rw    <= req_rw[w_win];
            r_m_addr  <= req_addr[7*int'(w_win) +: 7];
            r_m_wdata <= req_wdata[8*int'(w_win) +: 8];
`ifndef I2C_ARB_FIXED_PRIO_EN
            r_ptr     <= w_win;
`endif
            r_state   <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_cnt     <= '0;
          r_m_start <= 1'b1;
          r_state   <= S_LAUNCH;
        end
        // start stays high until the master reports busy; it only samples on slow SCL edges.
        S_LAUNCH: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == TO_LAST) begin
            r_m_start   <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= onehot(r_win);
            r_state     <= S_RESP;
          end else if (r_busy_s) begin
            r_m_start <= 1'b0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_done_rise) begin
            r_rsp_rdata <= m_data_out;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= onehot(r_win);
            r_state     <= S_RESP;
          end else if (r_cnt == TO_LAST) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= onehot(r_win);
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          r_rsp_valid <= '0;
          r_gnt       <= '0;
          r_m_start   <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt          = r_gnt;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_err      = r_rsp_err;
  assign m_start      = r_m_start;
  assign m_read_write = r_m_rw;
  assign m_slave_addr = r_m_addr;
  assign m_data_in    = r_m_wdata;

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Shares one i2c_master instance between NUM_REQ requesters (sensor poller, config loader, debug port, ...).
- Arbitrates round-robin, latches the winner's transaction, and drives the master's start/read_write/slave_addr/data_in.
- Tracks the master's busy/done flags, which come from the master's divided SCL domain.
- Returns a one-cycle response with read data and an error flag to the granted requester; a watchdog recovers from a hung master.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 200000, clk cycles allowed in LAUNCH plus WAIT before abort (4 ms at 50 MHz).
- TW, 18, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  50 MHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level; held until own rsp_valid.
- req_rw  in  NUM_REQ  per-requester R/W bit, 1 = read.
- req_addr  in  7*NUM_REQ  per-requester slave address; slice i = [7i+6:7i].
- req_wdata  in  8*NUM_REQ  per-requester write byte; slice i = [8i+7:8i].
- gnt  out  NUM_REQ  one-hot grant, high from GRANT through RESP.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rsp_rdata  out  8  read byte; valid with rsp_valid.
- rsp_err  out  1  1 = timeout abort; valid with rsp_valid.
- m_start  out  1  to master start.
- m_read_write  out  1  to master read_write.
- m_slave_addr  out  7  to master slave_addr.
- m_data_in  out  8  to master data_in.
- m_data_out  in  8  from master data_out.
- m_busy  in  1  from master busy (SCL domain).
- m_done  in  1  from master done (SCL domain).

Behaviour:
- Reset (async, rst_n low): state IDLE.
  - All outputs 0: gnt, rsp_valid, rsp_rdata, rsp_err, m_start, m_read_write, m_slave_addr, m_data_in.
  - RR pointer = NUM_REQ-1, so req[0] wins first.
  - Timeout counter 0; synchronizers cleared.
  - Reset mid-transaction drops m_start immediately; no response is issued.
- Synchronization:
  - m_busy and m_done each pass through a 2-flop synchronizer: busy_s, done_s.
  - done_rise = done_s & ~done_s_d.
- States:
  - IDLE: if any req bit is set, go to GRANT. Winner = first set bit searching from pointer+1 with wrap-around. Latch the winner index and its rw/addr/wdata into holding registers. Set pointer = winner.
  - GRANT (1 cycle): gnt[winner]=1. Drive m_* from the holding registers; they stay stable until IDLE. Clear timeout counter. Go to LAUNCH.
  - LAUNCH: m_start=1, held high because the master samples only on slow SCL edges. When busy_s=1, deassert m_start and go to WAIT.
  - WAIT: m_start=0. On done_rise, capture m_data_out into rsp_rdata (for writes the value is don't-care and is captured anyway), set rsp_err=0, go to RESP.
  - RESP (1 cycle): rsp_valid[winner]=1, gnt[winner] stays 1. Then go to IDLE with gnt=0 and m_start=0. rsp_rdata and rsp_err hold until the next RESP.
- Timeout:
  - The counter increments every cycle in LAUNCH and WAIT.
  - When it reaches TIMEOUT_CYCLES-1: m_start=0, rsp_err=1, rsp_rdata=0, go to RESP.
  - A done_rise in the same cycle as expiry takes priority: normal completion, rsp_err=0.
- Timing:
  - Minimum request-to-gnt latency: 1 cycle (IDLE sample, gnt visible in GRANT).
  - Back-to-back: at least 1 IDLE cycle between RESP and the next GRANT.
- Boundary conditions:
  - No requests: remain in IDLE, outputs idle.
  - Requester drops req after grant: the transaction still completes and rsp_valid still pulses; the requester ignores it.
  - Simultaneous requests: exactly one is granted; the others wait with no starvation (each waits at most NUM_REQ-1 transactions).
  - Stale done on entry: if done_s is already high entering LAUNCH, no done_rise is generated until it falls and rises again.

Optional Feature:
- Macro: I2C_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the pointer is not used or updated.
- Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Single request: req=0001, rw=0, addr=0x50, wdata=0xA5; model returns busy, then done. Expect: gnt=0001, m_slave_addr=0x50, m_data_in=0xA5, m_start held until busy_s, one rsp_valid=0001 pulse, rsp_err=0.
- Read: req[2] with rw=1, addr=0x68; model data_out=0x3C. Expect: rsp_valid=0100, rsp_rdata=0x3C, m_read_write=1.
- Round-robin: req=1111 held continuously for 8 transactions. Grant order 0,1,2,3,0,1,2,3; with the macro defined, grant order is 0 every time.
- Timeout: TIMEOUT_CYCLES=100, model never asserts busy. After 100 cycles in LAUNCH: m_start=0, rsp_valid pulses, rsp_err=1, rsp_rdata=0x00. The next request proceeds normally.
- Reset mid-WAIT: assert rst_n low while gnt=0010. All outputs go to 0 asynchronously and no rsp_valid is issued. After release, req=0011 grants requester 0 first.
- Done/timeout collision: done_rise lands on the expiry cycle. Expect rsp_err=0 and rsp_rdata=m_data_out.
